gcm_auth_decrypt: RTL and testbench

Receive-side counterpart of the GCM encryption path: takes AAD and ciphertext blocks plus externally generated CTR keystream blocks, recovers plaintext, runs GHASH with a bit-serial GF(2^128) multiplier, forms the expected tag from E(K,J0), and compares it with the received tag. Sits after the AES key/counter engine, which supplies H = E(K,0^128), E(K,J0) and one keystream block per ciphertext block. Whole blocks only; no partial-block support.

---
 rtl/gcm_auth_decrypt.sv | 164 ++++++++++++++++
 tb/tb_gcm_auth_decrypt.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gcm_auth_decrypt.sv
`default_nettype none
// ============================================================================
// Module   : gcm_auth_decrypt
// Purpose  : GCM receive path. CTR-decrypts ciphertext with an external keystream,
//            runs GHASH over AAD, ciphertext and the length block using a
//            bit-serial GF(2^128) multiplier, then checks the received tag.
// Revision : 1.0  initial release
// ============================================================================
module gcm_auth_decrypt (
    input  logic         clk,
    input  logic         i_reset_n,
    input  logic         i_start,
    input  logic [0:127] i_h,
    input  logic [0:127] i_ek_j0,
    input  logic [0:127] i_tag,
    input  logic [0:63]  i_aad_size,
    input  logic [0:63]  i_ct_size,
    input  logic         i_blk_valid,
    input  logic [0:127] i_blk,
    input  logic [0:127] i_keystream,
    output logic         o_blk_ready,
    output logic         o_pt_valid,
    output logic [0:127] o_plain_text,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_tag_ok
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_AAD = 3'd1,
        ST_WAIT_CT  = 3'd2,
        ST_MULT     = 3'd3,
        ST_LEN      = 3'd4,
        ST_MULT_LEN = 3'd5,
        ST_FINAL    = 3'd6,
        ST_DONE     = 3'd7
    } state_t;

    // GCM reduction constant: x^128 + x^7 + x^2 + x + 1 in reflected bit order
    localparam logic [0:127] C_R = {8'hE1, 120'd0};

    state_t        r_state;
    logic [0:127]  r_s;
    logic [0:127]  r_x;
    logic [0:127]  r_z;
    logic [0:127]  r_v;
    logic [0:127]  r_h;
    logic [0:127]  r_ek_j0;
    logic [0:127]  r_tag;
    logic [0:63]   r_aad_size;
    logic [0:63]   r_ct_size;
    logic [0:56]   r_aad_rem;
    logic [0:56]   r_ct_rem;
    logic [6:0]    r_cnt;
    logic          r_match;

    logic [0:127]  w_z_next;
    logic [0:127]  w_v_next;

    function automatic state_t next_phase(input logic [0:56] aad_rem, input logic [0:56] ct_rem);
        if (aad_rem != 57'd0)
            return ST_WAIT_AAD;
        else if (ct_rem != 57'd0)
            return ST_WAIT_CT;
        else
            return ST_LEN;
    endfunction

    // r_x shifts left each cycle so the multiplier bit under test is always r_x[0]
    assign w_z_next = r_x[0] ? (r_z ^ r_v) : r_z;
    assign w_v_next = r_v[127] ? ((r_v >> 1) ^ C_R) : (r_v >> 1);

    assign o_blk_ready = (r_state == ST_WAIT_AAD) || (r_state == ST_WAIT_CT);

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= ST_IDLE;
            r_s          <= '0;
            r_x          <= '0;
            r_z          <= '0;
            r_v          <= '0;
            r_h          <= '0;
            r_ek_j0      <= '0;
            r_tag        <= '0;
            r_aad_size   <= '0;
            r_ct_size    <= '0;
            r_aad_rem    <= '0;
            r_ct_rem     <= '0;
            r_cnt        <= '0;
            r_match      <= 1'b0;
            o_pt_valid   <= 1'b0;
            o_plain_text <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_tag_ok     <= 1'b0;
        end else begin
            o_pt_valid <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_h        <= i_h;
                        r_ek_j0    <= i_ek_j0;
                        r_tag      <= i_tag;
                        r_aad_size <= i_aad_size;
                        r_ct_size  <= i_ct_size;
                        r_aad_rem  <= i_aad_size[0:56];
                        r_ct_rem   <= i_ct_size[0:56];
                        r_s        <= '0;
                        o_busy     <= 1'b1;
                        o_done     <= 1'b0;
                        o_tag_ok   <= 1'b0;
                        r_state    <= next_phase(i_aad_size[0:56], i_ct_size[0:56]);
                    end else if ((r_state == ST_DONE) && !o_done) begin
                        // completion flags are presented one cycle after entering DONE
                        o_done   <= 1'b1;
                        o_tag_ok <= r_match;
                        o_busy   <= 1'b0;
                    end
                end
                ST_WAIT_AAD, ST_WAIT_CT: begin
                    if (i_blk_valid) begin
                        r_x     <= r_s ^ i_blk;
                        r_z     <= '0;
                        r_v     <= r_h;
                        r_cnt   <= 7'd0;
                        r_state <= ST_MULT;
                        if (r_state == ST_WAIT_CT) begin
                            o_plain_text <= i_blk ^ i_keystream;
                            o_pt_valid   <= 1'b1;
                            r_ct_rem     <= r_ct_rem - 57'd1;
                        end else begin
                            r_aad_rem <= r_aad_rem - 57'd1;
                        end
                    end
                end
                ST_MULT, ST_MULT_LEN: begin
                    r_z   <= w_z_next;
                    r_v   <= w_v_next;
                    r_x   <= r_x << 1;
                    r_cnt <= r_cnt + 7'd1;
                    if (r_cnt == 7'd127) begin
                        r_s     <= w_z_next;
                        r_state <= (r_state == ST_MULT) ? next_phase(r_aad_rem, r_ct_rem) : ST_FINAL;
                    end
                end
                ST_LEN: begin
                    r_x     <= r_s ^ {r_aad_size, r_ct_size};
                    r_z     <= '0;
                    r_v     <= r_h;
                    r_cnt   <= 7'd0;
                    r_state <= ST_MULT_LEN;
                end
                ST_FINAL: begin
                    r_match <= ((r_s ^ r_ek_j0) == r_tag);
                    r_state <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gcm_auth_decrypt.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcm_auth_decrypt
// Purpose  : Table-driven bench for gcm_auth_decrypt using NIST and model vectors.
// Revision : 1.0  initial release
// ============================================================================
module tb_gcm_auth_decrypt;

    logic         clk;
    logic         i_reset_n;
    logic         i_start;
    logic [127:0] i_h;
    logic [127:0] i_ek_j0;
    logic [127:0] i_tag;
    logic [63:0]  i_aad_size;
    logic [63:0]  i_ct_size;
    logic         i_blk_valid;
    logic [127:0] i_blk;
    logic [127:0] i_keystream;
    logic         o_blk_ready;
    logic         o_pt_valid;
    logic [127:0] o_plain_text;
    logic         o_busy;
    logic         o_done;
    logic         o_tag_ok;

    gcm_auth_decrypt dut (
        .clk          (clk),
        .i_reset_n    (i_reset_n),
        .i_start      (i_start),
        .i_h          (i_h),
        .i_ek_j0      (i_ek_j0),
        .i_tag        (i_tag),
        .i_aad_size   (i_aad_size),
        .i_ct_size    (i_ct_size),
        .i_blk_valid  (i_blk_valid),
        .i_blk        (i_blk),
        .i_keystream  (i_keystream),
        .o_blk_ready  (o_blk_ready),
        .o_pt_valid   (o_pt_valid),
        .o_plain_text (o_plain_text),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_tag_ok     (o_tag_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0]        h;
        logic [127:0]        ek;
        logic [127:0]        tag;
        logic [63:0]         aad_size;
        logic [63:0]         ct_size;
        logic [3:0][127:0]   blk;
        logic [3:0][127:0]   ks;
        bit                  exp_ok;
        int                  exp_done;
        int                  inject_at;
        bit                  chk_gap;
    } vec_t;

    localparam logic [127:0] C_H1 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] C_EK1 = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    localparam logic [127:0] C_C2 = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] C_T2 = 128'hab6e47d42cec13bdf53a67b21257bddf;
    localparam logic [127:0] C_Z = 128'd0;

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vecs [8];
    vec_t vtmp;

    task automatic check128(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic checki(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // GF(2^128) product in GCM bit order; standard [127:0] MSB is GCM bit 0
    function automatic logic [127:0] gmul(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] z;
        logic [127:0] v;
        z = '0;
        v = y;
        for (int i = 0; i < 128; i++) begin
            if (x[127-i]) z = z ^ v;
            v = v[0] ? ((v >> 1) ^ {8'he1, 120'd0}) : (v >> 1);
        end
        return z;
    endfunction

    function automatic logic [127:0] model_tag(input vec_t v);
        logic [127:0] s;
        int nblk;
        s = '0;
        nblk = int'(v.aad_size >> 7) + int'(v.ct_size >> 7);
        for (int i = 0; i < nblk; i++) s = gmul(s ^ v.blk[i], v.h);
        s = gmul(s ^ {v.aad_size, v.ct_size}, v.h);
        return s ^ v.ek;
    endfunction

    function automatic vec_t mk(input logic [127:0] h, input logic [127:0] ek, input logic [127:0] tg,
                                input logic [63:0] asz, input logic [63:0] csz,
                                input logic [127:0] b0, input logic [127:0] b1,
                                input logic [127:0] b2, input logic [127:0] b3,
                                input logic [127:0] k0, input logic [127:0] k1,
                                input logic [127:0] k2, input logic [127:0] k3,
                                input bit ok, input int inj, input bit gap);
        vec_t v;
        v.h = h; v.ek = ek; v.tag = tg; v.aad_size = asz; v.ct_size = csz;
        v.blk = {b3, b2, b1, b0};
        v.ks  = {k3, k2, k1, k0};
        v.exp_ok = ok; v.inject_at = inj; v.chk_gap = gap;
        v.exp_done = 132 + 129 * (int'(asz >> 7) + int'(csz >> 7));
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string nm, input int abort_at);
        int cyc, idx, nacc, npt, last_acc, nblk, naad;
        bit will_acc, prev_ct;
        logic [127:0] exp_pt;
        naad = int'(v.aad_size >> 7);
        nblk = naad + int'(v.ct_size >> 7);
        i_h = v.h; i_ek_j0 = v.ek; i_tag = v.tag;
        i_aad_size = v.aad_size; i_ct_size = v.ct_size;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        cyc = 1;
        checki({nm, ".busy_rise"}, int'(o_busy), 1);
        checki({nm, ".done_clear"}, int'(o_done), 0);
        checki({nm, ".tag_ok_clear"}, int'(o_tag_ok), 0);
        idx = 0; nacc = 0; npt = 0; last_acc = 0; prev_ct = 1'b0; exp_pt = '0;
        while (!o_done && cyc < 4000) begin
            if (o_pt_valid) begin
                npt++;
                checki({nm, ".pt_after_ct_accept"}, int'(prev_ct), 1);
                if (prev_ct) check128({nm, ".pt_data"}, o_plain_text, exp_pt);
            end
            if (cyc == v.inject_at) begin
                i_start = 1'b1; i_tag = ~v.tag; i_h = ~v.h; i_aad_size = '0; i_ct_size = '0;
            end else begin
                i_start = 1'b0;
            end
            if (idx < nblk) begin
                i_blk_valid = 1'b1; i_blk = v.blk[idx]; i_keystream = v.ks[idx];
            end else begin
                i_blk_valid = 1'b0;
            end
            will_acc = i_blk_valid && o_blk_ready;
            prev_ct = will_acc && (idx >= naad);
            if (will_acc) begin
                exp_pt = v.blk[idx] ^ v.ks[idx];
                if (v.chk_gap && nacc > 0) checki({nm, ".accept_gap"}, cyc - last_acc, 129);
                last_acc = cyc;
                nacc++;
                idx++;
            end
            if (abort_at != 0 && cyc == abort_at) begin
                #2 i_reset_n = 1'b0;
                #1;
                checki({nm, ".rst_ready"}, int'(o_blk_ready), 0);
                checki({nm, ".rst_pt_valid"}, int'(o_pt_valid), 0);
                checki({nm, ".rst_busy"}, int'(o_busy), 0);
                checki({nm, ".rst_done"}, int'(o_done), 0);
                checki({nm, ".rst_tag_ok"}, int'(o_tag_ok), 0);
                check128({nm, ".rst_plain_text"}, o_plain_text, C_Z);
                i_blk_valid = 1'b0; i_start = 1'b0;
                @(posedge clk); @(posedge clk); #1;
                i_reset_n = 1'b1;
                return;
            end
            @(posedge clk); #1;
            cyc++;
        end
        i_blk_valid = 1'b0;
        i_start = 1'b0;
        checki({nm, ".done_seen"}, int'(o_done), 1);
        checki({nm, ".done_cycle"}, cyc, v.exp_done);
        checki({nm, ".accepts"}, nacc, nblk);
        checki({nm, ".pt_pulses"}, npt, nblk - naad);
        checki({nm, ".tag_ok"}, int'(o_tag_ok), int'(v.exp_ok));
        checki({nm, ".busy_fall"}, int'(o_busy), 0);
        checki({nm, ".ready_low"}, int'(o_blk_ready), 0);
    endtask

    initial begin
        i_reset_n = 1'b0; i_start = 1'b0; i_h = '0; i_ek_j0 = '0; i_tag = '0;
        i_aad_size = '0; i_ct_size = '0; i_blk_valid = 1'b0; i_blk = '0; i_keystream = '0;

        vecs[0] = mk(C_H1, C_EK1, C_EK1, 64'd0, 64'd0, C_Z, C_Z, C_Z, C_Z, C_Z, C_Z, C_Z, C_Z, 1'b1, 0, 1'b0);
        vecs[1] = mk(C_H1, C_EK1, C_T2, 64'd0, 64'd128, C_C2, C_Z, C_Z, C_Z, C_C2, C_Z, C_Z, C_Z, 1'b1, 0, 1'b0);
        vecs[2] = mk(C_H1, C_EK1, C_T2 ^ 128'd1, 64'd0, 64'd128, C_C2, C_Z, C_Z, C_Z,
                     C_C2, C_Z, C_Z, C_Z, 1'b0, 0, 1'b0);
        vecs[3] = mk(C_H1, C_EK1, C_T2, 64'd0, 64'd128, C_C2 ^ {1'b1, 127'd0}, C_Z, C_Z, C_Z,
                     C_C2, C_Z, C_Z, C_Z, 1'b0, 0, 1'b0);
        vecs[4] = mk(128'hb83b533708bf535d0aa6e52980d53b78, 128'h3247184b3c4f69a44dbcd22887bbb418, C_Z,
                     64'd256, 64'd256,
                     128'hfeedfacedeadbeeffeedfacedeadbeef, 128'habaddad2000000000000000000000000,
                     128'h42831ec2217774244b7221b784d0d49c, 128'he3aa212f2c02a4e035c17e2329aca12e,
                     C_Z, C_Z, 128'h0123456789abcdef0f1e2d3c4b5a6978, 128'hffffffff00000000aaaaaaaa55555555,
                     1'b1, 0, 1'b1);
        vecs[4].tag = model_tag(vecs[4]);
        vecs[5] = vecs[4];
        vecs[5].tag = vecs[4].tag ^ {64'd1, 64'd0};
        vecs[5].exp_ok = 1'b0;
        vecs[6] = mk(C_H1, 128'h00112233445566778899aabbccddeeff, C_Z, 64'd133, 64'd0,
                     128'hdeadbeefcafef00d0badc0de12345678, C_Z, C_Z, C_Z, C_Z, C_Z, C_Z, C_Z,
                     1'b1, 0, 1'b0);
        vecs[6].tag = model_tag(vecs[6]);
        vecs[7] = vecs[1];
        vecs[7].inject_at = 50;

        repeat (3) @(posedge clk);
        #1;
        checki("reset.ready", int'(o_blk_ready), 0);
        checki("reset.pt_valid", int'(o_pt_valid), 0);
        check128("reset.plain_text", o_plain_text, C_Z);
        checki("reset.busy", int'(o_busy), 0);
        checki("reset.done", int'(o_done), 0);
        checki("reset.tag_ok", int'(o_tag_ok), 0);
        i_reset_n = 1'b1;
        @(posedge clk); #1;

        // consecutive runs without reset exercise restart from DONE
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i), 0);
            @(posedge clk); #1;
        end

        vtmp = vecs[3];
        run_vec(vtmp, "abort", 60);
        run_vec(vecs[1], "after_abort", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
